// File: rtl/iterative_mult_unit.sv
// Multi-cycle shift-add multiplier for MULT/MULTU with architectural HI/LO.
// One multiplier bit is consumed per clock, LSB first; sign is applied once at the end.
module iterative_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             WriteHi,
    input  logic             WriteLo,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    // state | meaning
    // IDLE  | waiting for Start; MTHI/MTLO writes honoured
    // RUN   | one shift-add step per edge, WIDTH steps
    // FIN   | sign-correct accumulator into Hi/Lo, pulse Done
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH-1:0]   mag_a_d;
    logic [WIDTH-1:0]   mag_b_d;
    logic [WIDTH:0]     sum_d;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_d;

    always_comb begin
        // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
        mag_a_d = (Signed && inA[WIDTH-1]) ? -inA : inA;
        mag_b_d = (Signed && inB[WIDTH-1]) ? -inB : inB;
        sum_d   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_d   = {sum_d, acc_q[WIDTH-1:1]};
        prod_d  = neg_q ? -acc_q : acc_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (WriteHi) hi_q <= WrData;
                    if (WriteLo) lo_q <= WrData;
                    if (Start) begin
                        mcand_q  <= mag_a_d;
                        mplier_q <= mag_b_d;
                        neg_q    <= Signed & (inA[WIDTH-1] ^ inB[WIDTH-1]);
                        cnt_q    <= '0;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + ONE;
                    if (cnt_q == LAST) state_q <= FIN;
                end
                FIN: begin
                    {hi_q, lo_q} <= prod_d;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule

// File: tb/tb_iterative_mult_unit.sv
// Self-checking bench for iterative_mult_unit: directed corner products, random
// products against a plain-arithmetic reference, MTHI/MTLO, busy-time disturbance and async reset.
module tb_iterative_mult_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start, Signed, WriteHi, WriteLo;
    logic [31:0] inA, inB, WrData;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int n_tests = 0;
    int n_fail  = 0;

    iterative_mult_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Signed(Signed),
        .inA(inA), .inB(inB), .WriteHi(WriteHi), .WriteLo(WriteLo),
        .WrData(WrData), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s, input bit disturb);
        logic [63:0] exp;
        logic [31:0] hi0, lo0;
        int          nb;
        bit          hold_bad;
        exp = ref_prod(a, b, s);
        hi0 = Hi;
        lo0 = Lo;
        Start = 1'b1; Signed = s; inA = a; inB = b;
        step();
        Start = 1'b0;
        inA = $urandom; inB = $urandom; Signed = 1'($urandom);
        chk("done_pulse_width", {63'b0, Done}, 64'd0);
        nb = 0;
        hold_bad = 1'b0;
        for (int i = 0; i < 100 && !Done; i++) begin
            if (Busy) nb++;
            if (Hi !== hi0 || Lo !== lo0) hold_bad = 1'b1;
            if (disturb && i == 10) begin
                Start = 1'b1; WriteHi = 1'b1; WriteLo = 1'b1; WrData = 32'h1234;
            end else if (disturb && i == 11) begin
                Start = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
            end
            step();
        end
        chk("busy_cycles", 64'(nb), 64'd33);
        chk("done_not_busy", {62'b0, Done, Busy}, 64'b10);
        chk("hold_during_busy", {63'b0, hold_bad}, 64'd0);
        chk("product", {Hi, Lo}, exp);
    endtask

    initial begin
        logic [31:0] hprev, d1, d2;
        int          ndone;
        Rst = 1'b0; Start = 1'b0; Signed = 1'b0; WriteHi = 1'b0; WriteLo = 1'b0;
        inA = '0; inB = '0; WrData = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_state", {28'b0, Busy, Done, 2'b0, Hi}, 64'd0);
        chk("reset_lo", {32'b0, Lo}, 64'd0);
        Rst = 1'b1;
        step();

        // Directed corner products
        do_mult(32'd7, 32'd6, 1'b0, 1'b0);
        chk("7x6_lo", {Hi, Lo}, 64'h0000_0000_0000_002A);
        do_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        chk("m3x5", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("ffxff_u", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("ffxff_s", {Hi, Lo}, 64'h0000_0000_0000_0001);
        do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        chk("minxmin_s", {Hi, Lo}, 64'h4000_0000_0000_0000);
        do_mult(32'h8000_0000, 32'd1, 1'b1, 1'b0);
        chk("minx1_s", {Hi, Lo}, 64'hFFFF_FFFF_8000_0000);

        // Random products, some back-to-back, some with idle gaps
        for (int k = 0; k < 24; k++) begin
            d1 = $urandom;
            d2 = (k % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            do_mult(d1, d2, 1'($urandom), 1'b0);
            if (k % 3 == 0) repeat ($urandom_range(1, 3)) step();
        end

        // Start, MTHI/MTLO and operand changes during a busy multiply are ignored
        do_mult(32'h0001_1111, 32'h0002_2222, 1'b0, 1'b1);
        chk("busy_write_ignored", {63'b0, (Hi == 32'h1234)}, 64'd0);
        chk("busy_start_ignored", {63'b0, Busy}, 64'd0);

        // MTLO alone, then MTHI+MTLO together in IDLE
        step();
        hprev = Hi;
        WriteLo = 1'b1; WrData = 32'h0000_ABCD;
        step();
        WriteLo = 1'b0;
        chk("mtlo", {Hi, Lo}, {hprev, 32'h0000_ABCD});
        d1 = $urandom;
        WriteHi = 1'b1; WriteLo = 1'b1; WrData = d1;
        step();
        WriteHi = 1'b0; WriteLo = 1'b0;
        chk("mthi_mtlo", {Hi, Lo}, {d1, d1});

        // Start together with MTHI in IDLE: product overwrites the write
        WriteHi = 1'b1; WrData = 32'h5555_0000;
        Start = 1'b1; Signed = 1'b0; inA = 32'd9; inB = 32'd11;
        step();
        WriteHi = 1'b0; Start = 1'b0;
        chk("start_write_lands", {32'b0, Hi}, 64'h5555_0000);
        for (int i = 0; i < 100 && !Done; i++) step();
        chk("start_write_product", {Hi, Lo}, 64'd99);

        // Asynchronous reset in the middle of RUN
        do_mult(32'h1234_5678, 32'h9ABC_DEF1, 1'b0, 1'b0);
        Start = 1'b1; Signed = 1'b0; inA = 32'd5; inB = 32'd7;
        step();
        Start = 1'b0;
        repeat (11) step();
        #2 Rst = 1'b0;
        #1;
        chk("rst_mid_busy", {62'b0, Busy, Done}, 64'd0);
        chk("rst_mid_hilo", {Hi, Lo}, 64'd0);
        step();
        step();
        Rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done || Busy) ndone++;
            step();
        end
        chk("no_done_after_rst", 64'(ndone), 64'd0);
        do_mult(32'd2, 32'd3, 1'b0, 1'b0);
        chk("post_rst_2x3", {32'b0, Lo}, 64'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
